// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared core widths
// Purpose: data/address width and byte-mask width used by the memory arbiter.
package core_pkg;
  localparam int unsigned Xlen     = 32;
  localparam int unsigned MaskBits = Xlen / 8;
endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - fetch/LSU/memory bus bundle for mem_arbiter
// Purpose: groups the fetch, LSU and shared-memory handshake and data signals.
// Modports:
//   master - arbiter side: takes requests, drives memory request and responses
//   slave  - environment side: drives requests, memory ready and memory responses
interface mem_arbiter_if;
  logic                         if_valid_i;
  logic                         if_ready_o;
  logic [core_pkg::Xlen-1:0]    if_addr_i;
  logic [core_pkg::Xlen-1:0]    if_rdata_o;
  logic                         if_rvalid_o;

  logic                         ls_valid_i;
  logic                         ls_ready_o;
  logic [core_pkg::Xlen-1:0]    ls_addr_i;
  logic [core_pkg::Xlen-1:0]    ls_wdata_i;
  logic [core_pkg::MaskBits-1:0] ls_wmask_i;
  logic [core_pkg::Xlen-1:0]    ls_rdata_o;
  logic                         ls_rvalid_o;

  logic                         mem_valid_o;
  logic                         mem_ready_i;
  logic [core_pkg::Xlen-1:0]    mem_addr_o;
  logic [core_pkg::Xlen-1:0]    mem_wdata_o;
  logic [core_pkg::MaskBits-1:0] mem_wmask_o;
  logic [core_pkg::Xlen-1:0]    mem_rdata_i;
  logic                         mem_rvalid_i;

  modport master (
    input  if_valid_i, if_addr_i,
    output if_ready_o, if_rdata_o, if_rvalid_o,
    input  ls_valid_i, ls_addr_i, ls_wdata_i, ls_wmask_i,
    output ls_ready_o, ls_rdata_o, ls_rvalid_o,
    output mem_valid_o, mem_addr_o, mem_wdata_o, mem_wmask_o,
    input  mem_ready_i, mem_rdata_i, mem_rvalid_i
  );

  modport slave (
    output if_valid_i, if_addr_i,
    input  if_ready_o, if_rdata_o, if_rvalid_o,
    output ls_valid_i, ls_addr_i, ls_wdata_i, ls_wmask_i,
    input  ls_ready_o, ls_rdata_o, ls_rvalid_o,
    input  mem_valid_o, mem_addr_o, mem_wdata_o, mem_wmask_o,
    output mem_ready_i, mem_rdata_i, mem_rvalid_i
  );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester arbiter onto one in-order memory port
// Purpose: arbitrates fetch and LSU requests onto a shared memory port with
//   zero-cycle request latency, locks the winner while the port stalls, and
//   routes in-order responses back using a FIFO of source IDs.
// Ports:
//   clk_i  - clock
//   rst_i  - asynchronous active-high reset
//   bus    - mem_arbiter_if.master (fetch, LSU and memory handshakes/data)
//   err_o  - sticky: a response arrived with nothing outstanding
// Parameter: MaxOutstanding - accepted-but-unanswered requests (power of two, 1..8)
// Build option: MEM_ARB_ROUND_ROBIN_EN - ties go to the requester not granted at
//   the last acceptance; otherwise the LSU always wins ties.
module mem_arbiter #(
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  mem_arbiter_if.master bus,
  output logic          err_o
);
  localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

  typedef enum logic {StOpen, StLocked} state_e;

  state_e            state_q, state_d;
  logic              sel_q, sel_d;        // latched source while locked (1 = LSU)
  logic              sel;                 // source currently presented
  logic              open_sel;
  logic              tie_pick;            // source chosen when both are valid
  logic              req_valid;
  logic              mem_valid;
  logic              accept;
  logic              pop;
  logic              head;
  logic              full;
  logic              err_q, err_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              fifo_q [MaxOutstanding];

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    if (p == PtrW'(MaxOutstanding - 1)) return '0;
    return p + PtrW'(1);
  endfunction

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_q;   // source granted at the last acceptance (1 = LSU)

  assign tie_pick = ~last_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_q <= 1'b0;
    end else if (accept) begin
      last_q <= sel;
    end
  end
`else
  assign tie_pick = 1'b1;
`endif

  // Full comes from the registered count so a same-cycle pop cannot unblock.
  assign full     = (count_q == CntW'(MaxOutstanding));
  assign open_sel = (bus.if_valid_i && bus.ls_valid_i) ? tie_pick : bus.ls_valid_i;

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    sel       = sel_q;
    req_valid = 1'b0;
    if (state_q == StOpen) begin
      sel       = open_sel;
      req_valid = (bus.if_valid_i || bus.ls_valid_i) && !full;
    end else begin
      req_valid = sel_q ? bus.ls_valid_i : bus.if_valid_i;
    end
    mem_valid = req_valid && !rst_i;
    if (state_q == StOpen) begin
      if (mem_valid && !bus.mem_ready_i) begin
        state_d = StLocked;
        sel_d   = sel;
      end
    end else if (bus.mem_ready_i) begin
      state_d = StOpen;
    end
  end

  assign accept          = mem_valid && bus.mem_ready_i;
  assign bus.mem_valid_o = mem_valid;
  assign bus.mem_addr_o  = sel ? bus.ls_addr_i  : bus.if_addr_i;
  assign bus.mem_wdata_o = sel ? bus.ls_wdata_i : '0;
  assign bus.mem_wmask_o = sel ? bus.ls_wmask_i : '0;
  assign bus.if_ready_o  = accept && !sel;
  assign bus.ls_ready_o  = accept && sel;

  // Responses are in order, so the FIFO head names the requester being answered.
  assign pop             = bus.mem_rvalid_i && (count_q != '0) && !rst_i;
  assign head            = fifo_q[rd_ptr_q];
  assign bus.if_rvalid_o = pop && !head;
  assign bus.ls_rvalid_o = pop && head;
  assign bus.if_rdata_o  = bus.mem_rdata_i;
  assign bus.ls_rdata_o  = bus.mem_rdata_i;

  always_comb begin
    wr_ptr_d = accept ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop    ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    if (accept && !pop) count_d = count_q + CntW'(1);
    if (!accept && pop) count_d = count_q - CntW'(1);
    err_d    = err_q || (bus.mem_rvalid_i && (count_q == '0));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= StOpen;
      sel_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  // ID storage needs no reset: entries are only read below the valid count.
  always_ff @(posedge clk_i) begin
    if (accept) fifo_q[wr_ptr_q] <= sel;
  end

  assign err_o = err_q;
endmodule
